// File: rtl/retry_pkg.sv
// retry_pkg: shared types and widths for the link-layer retry state machine.
// Build option: RETRY_TIMEOUT_EN enables the LOCAL_IDLE timeout (see retry_lrsm).
package retry_pkg;

    localparam int unsigned ESEQ_W      = 8;
    localparam int unsigned NUM_RETRY_W = 5;
    localparam int unsigned TIMEOUT_W   = 12;

    typedef enum logic [2:0] {
        StNormal    = 3'd0,
        StLlrReq    = 3'd1,
        StLocalIdle = 3'd2,
        StPhyReinit = 3'd3,
        StAbort     = 3'd4
    } lrsm_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [NUM_RETRY_W-1:0] sat_inc(input logic [NUM_RETRY_W-1:0] v);
        return (&v) ? v : v + NUM_RETRY_W'(1);
    endfunction

endpackage

// File: rtl/retry_lrsm_if.sv
// retry_lrsm_if: event inputs, register-file limits and RETRY.Req outputs of the LRSM.
// Build option: RETRY_TIMEOUT_EN (retry_timeout is only consumed when it is defined).
interface retry_lrsm_if;
    import retry_pkg::*;

    logic [ESEQ_W-1:0]      i_retry_eseq;
    logic                   i_crc_error;
    logic                   i_retry_ack_valid;
    logic                   i_phy_reinit_done;
    logic                   i_tx_retry_req_ready;
    logic [NUM_RETRY_W-1:0] i_register_file_max_num_retry;
    logic [NUM_RETRY_W-1:0] i_register_file_max_num_phy_reinit;
    logic [TIMEOUT_W-1:0]   i_register_file_retry_timeout;

    logic                   o_retry_req_valid;
    logic [ESEQ_W-1:0]      o_retry_req_eseq;
    logic [NUM_RETRY_W-1:0] o_retry_req_num_retry;
    logic                   o_phy_reinit_req;
    logic                   o_link_failure;
    logic [2:0]             o_lrsm_state;

    // master: the LRSM itself (source of RETRY.Req); slave: link/TX/PHY environment.
    modport master (
        input  i_retry_eseq, i_crc_error, i_retry_ack_valid, i_phy_reinit_done,
               i_tx_retry_req_ready, i_register_file_max_num_retry,
               i_register_file_max_num_phy_reinit, i_register_file_retry_timeout,
        output o_retry_req_valid, o_retry_req_eseq, o_retry_req_num_retry,
               o_phy_reinit_req, o_link_failure, o_lrsm_state
    );

    modport slave (
        output i_retry_eseq, i_crc_error, i_retry_ack_valid, i_phy_reinit_done,
               i_tx_retry_req_ready, i_register_file_max_num_retry,
               i_register_file_max_num_phy_reinit, i_register_file_retry_timeout,
        input  o_retry_req_valid, o_retry_req_eseq, o_retry_req_num_retry,
               o_phy_reinit_req, o_link_failure, o_lrsm_state
    );

endinterface

// File: rtl/retry_timer.sv
// retry_timer: loadable down-counter that stops at zero; expired while the count is zero.
// Only present when RETRY_TIMEOUT_EN is defined.
`ifdef RETRY_TIMEOUT_EN
module retry_timer
    import retry_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 load,
    input  logic [TIMEOUT_W-1:0] load_value,
    input  logic                 dec,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] count_q, count_d;

    // Load has priority; decrement never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - TIMEOUT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule
`endif

// File: rtl/retry_lrsm.sv
// retry_lrsm: link-layer retry state machine (NORMAL / LLRREQ / LOCAL_IDLE / PHY_REINIT /
// ABORT). Build option: define RETRY_TIMEOUT_EN to add the LOCAL_IDLE timeout; without it
// LOCAL_IDLE is left only on a RETRY.Ack.
module retry_lrsm
    import retry_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    retry_lrsm_if.master  bus
);

    lrsm_state_e            state_q, state_d;
    logic [ESEQ_W-1:0]      eseq_q, eseq_d;
    logic [NUM_RETRY_W-1:0] num_retry_q, num_retry_d;
    logic [NUM_RETRY_W-1:0] num_reinit_q, num_reinit_d;
    logic                   valid_q, valid_d;
    logic                   phy_req_q, phy_req_d;
    logic                   link_fail_q, link_fail_d;
    logic                   retry_limit_hit;
    logic                   reinit_limit_hit;

    assign retry_limit_hit  = (num_retry_q >= bus.i_register_file_max_num_retry);
    assign reinit_limit_hit = (num_reinit_q >= bus.i_register_file_max_num_phy_reinit);

`ifdef RETRY_TIMEOUT_EN
    logic timer_load, timer_dec, timer_expired;

    retry_timer u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .load       (timer_load),
        .load_value (bus.i_register_file_retry_timeout),
        .dec        (timer_dec),
        .expired    (timer_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^bus.i_register_file_retry_timeout;
`endif

    // Next-state, counter and latched-Eseq logic.
    always_comb begin
        state_d      = state_q;
        eseq_d       = eseq_q;
        num_retry_d  = num_retry_q;
        num_reinit_d = num_reinit_q;
`ifdef RETRY_TIMEOUT_EN
        timer_load   = 1'b0;
        timer_dec    = 1'b0;
`endif
        unique case (state_q)
            StNormal: begin
                if (bus.i_crc_error) begin
                    state_d = StLlrReq;
                    eseq_d  = bus.i_retry_eseq;
                end
            end
            StLlrReq: begin
                // Retry budget used up: escalate instead of issuing another Req.
                if (retry_limit_hit) begin
                    if (reinit_limit_hit) begin
                        state_d = StAbort;
                    end else begin
                        state_d      = StPhyReinit;
                        num_reinit_d = sat_inc(num_reinit_q);
                        num_retry_d  = '0;
                    end
                end else if (valid_q && bus.i_tx_retry_req_ready) begin
                    state_d     = StLocalIdle;
                    num_retry_d = sat_inc(num_retry_q);
`ifdef RETRY_TIMEOUT_EN
                    timer_load  = 1'b1;
`endif
                end
            end
            StLocalIdle: begin
                // Ack beats a simultaneous timeout.
                if (bus.i_retry_ack_valid) begin
                    state_d      = StNormal;
                    num_retry_d  = '0;
                    num_reinit_d = '0;
                end
`ifdef RETRY_TIMEOUT_EN
                else if (timer_expired) begin
                    state_d = StLlrReq;
                end else begin
                    timer_dec = 1'b1;
                end
`endif
            end
            StPhyReinit: begin
                if (bus.i_phy_reinit_done) begin
                    state_d = StLlrReq;
                    eseq_d  = bus.i_retry_eseq;
                end
            end
            StAbort: begin
                state_d = StAbort;
            end
            default: begin
                state_d = StNormal;
            end
        endcase
    end

    // Outputs are registered, so derive them from the next state and next counters.
    always_comb begin
        valid_d     = (state_d == StLlrReq) &&
                      (num_retry_d < bus.i_register_file_max_num_retry);
        phy_req_d   = (state_d == StPhyReinit);
        link_fail_d = (state_d == StAbort);
    end

    // State, counter and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StNormal;
            eseq_q       <= '0;
            num_retry_q  <= '0;
            num_reinit_q <= '0;
            valid_q      <= 1'b0;
            phy_req_q    <= 1'b0;
            link_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            eseq_q       <= eseq_d;
            num_retry_q  <= num_retry_d;
            num_reinit_q <= num_reinit_d;
            valid_q      <= valid_d;
            phy_req_q    <= phy_req_d;
            link_fail_q  <= link_fail_d;
        end
    end

    assign bus.o_retry_req_valid     = valid_q;
    assign bus.o_retry_req_eseq      = eseq_q;
    assign bus.o_retry_req_num_retry = num_retry_q;
    assign bus.o_phy_reinit_req      = phy_req_q;
    assign bus.o_link_failure        = link_fail_q;
    assign bus.o_lrsm_state          = state_q;

endmodule
